compress_offset_ctrl: RTL
=========================

Name: compress_offset_ctrl

Overview:
Sequencer for the vector-compress offset unit. It accepts a compress request of vl source elements and walks the unit two elements per cycle using ena/done. It collects the unit's wen/woffset outputs and presents them as registered, stall-aware write requests to the VRF write port. It reports completion, the total written-element count, and a protocol error flag.

Parameters:
VLMAX, 32, maximum source elements per request (even, power of 2)
VL_W, 6, width of vl/index/count fields, $clog2(VLMAX)+1
OFFSET_W, 5, width of offset_t (destination element offset)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only when ready=1
vl  input  VL_W  source element count, sampled with start; values >VLMAX clamp to VLMAX
ready  output  1  high in IDLE only
cou_ena  output  1  offset unit enable: process pair src_idx, src_idx+1
cou_done  output  1  high with cou_ena on the last pair
cou_busy  input  1  offset unit still active
cou_checking_mask0_1  input  1  unit is evaluating mask bits of pair 0
cou_wen  input  2  unit write enables for the current pair (combinational on cou_ena)
cou_woffset0  input  OFFSET_W  destination offset, lane 0
cou_woffset1  input  OFFSET_W  destination offset, lane 1
stall  input  1  VRF write port cannot accept this cycle
src_idx  output  VL_W  even index of the pair being processed
wr_en  output  2  registered write enables to the VRF
wr_idx0  output  OFFSET_W  registered destination, lane 0
wr_idx1  output  OFFSET_W  registered destination, lane 1
wcount  output  VL_W  elements accepted by the VRF for the current/last request
done  output  1  one-cycle completion pulse
err  output  1  sticky protocol error, cleared on start

Behaviour:
- Reset values (async): state=IDLE, ready=1. cou_ena, cou_done, src_idx, wr_en, wr_idx0/1, wcount, done, err all 0. vl_q=0.
- A reset mid-operation aborts immediately: no done pulse, and no write stays pending.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: on start, latch vl_q=min(vl,VLMAX), clear wcount and err, set src_idx=0. Go to FIN if vl_q=0, else RUN.
- RUN: cou_ena = !stall; cou_done = cou_ena & (src_idx+2 >= vl_q).
  - Non-stalled cycle: wr_en <= {cou_wen[1] & (src_idx+1 < vl_q), cou_wen[0]}; wr_idx0/1 <= cou_woffset0/1; src_idx += 2.
  - If cou_done, go to DRAIN.
- DRAIN: cou_ena=0. Go to FIN when cou_busy=0 and stall=0.
- FIN: done=1 for exactly one cycle, then IDLE.
- Write register rule: when stall=1, wr_en/wr_idx0/wr_idx1/src_idx hold. In any non-stalled cycle that loads no new pair, wr_en <= 0.
- wcount += popcount(wr_en) on every cycle with stall=0. Width is saturation-free because wcount <= VLMAX.
- Odd vl: lane 1 of the final pair is masked off regardless of cou_wen[1].
- err is set if cou_checking_mask0_1=1 while cou_ena=1 and src_idx!=0, or if cou_busy=0 while cou_ena=1 in RUN.
- start while ready=0 is ignored.
- Latency with no stall: start at T, RUN for ceil(vl/2) cycles, DRAIN 1 cycle minimum, done at T+ceil(vl/2)+2, ready again at T+ceil(vl/2)+3.

Test Plan:
1. vl=4, unit returns wen=11 with offsets (0,1) then (2,3). Required: cou_ena high at T+1 and T+2, cou_done at T+2 only. wr_en=11 with idx (0,1) at T+2 and (2,3) at T+3. done at T+4, wcount=4.
2. vl=5, unit returns wen=11 every pair with offsets 0..5. Required: third pair gives wr_en=01, idx0=4. wcount=5, done at T+5.
3. vl=0. Required: no cou_ena, done at T+1, wcount=0, ready=1 at T+2.
4. vl=4 with stall held high for 2 cycles during the first pair. Required: cou_ena low while stalled, src_idx held at 0. wr_* stable and accepted once stall drops. done delayed by 2 cycles, wcount=4.
5. vl=8, RST asserted after the second RUN cycle. Required: all outputs return to reset values immediately, ready=1, no done. A new start with vl=2 then completes normally with done at T+3.
6. vl=4 with cou_checking_mask0_1 held high on the pair at src_idx=2. Required: err=1 sticky through done, cleared by the next start. A start pulsed mid-run is ignored.

Source files
------------

// File: rtl/compress_offset_ctrl_if.sv
// Signal bundle between the compress offset sequencer and its surroundings:
// request/status handshake, compress offset unit (cou_*) and VRF write port.
// master = sequencer view, slave = environment (requester, offset unit, VRF).
interface compress_offset_ctrl_if #(
  parameter int VL_W     = 6,
  parameter int OFFSET_W = 5
);
  // request / status
  logic                start;
  logic [VL_W-1:0]     vl;
  logic                ready;
  logic                done;
  logic                err;
  logic [VL_W-1:0]     wcount;
  // offset unit
  logic                cou_ena;
  logic                cou_done;
  logic                cou_busy;
  logic                cou_checking_mask0_1;
  logic [1:0]          cou_wen;
  logic [OFFSET_W-1:0] cou_woffset0;
  logic [OFFSET_W-1:0] cou_woffset1;
  logic [VL_W-1:0]     src_idx;
  // VRF write port
  logic                stall;
  logic [1:0]          wr_en;
  logic [OFFSET_W-1:0] wr_idx0;
  logic [OFFSET_W-1:0] wr_idx1;

  modport master (
    input  start, vl, cou_busy, cou_checking_mask0_1, cou_wen,
           cou_woffset0, cou_woffset1, stall,
    output ready, done, err, wcount, cou_ena, cou_done, src_idx,
           wr_en, wr_idx0, wr_idx1
  );

  modport slave (
    output start, vl, cou_busy, cou_checking_mask0_1, cou_wen,
           cou_woffset0, cou_woffset1, stall,
    input  ready, done, err, wcount, cou_ena, cou_done, src_idx,
           wr_en, wr_idx0, wr_idx1
  );
endinterface

// File: rtl/compress_offset_ctrl.sv
// Vector-compress offset sequencer: walks the offset unit two source
// elements per cycle, registers its write enables/offsets into stall-aware
// VRF write requests, counts accepted elements and flags protocol errors.
module compress_offset_ctrl #(
  parameter int VLMAX    = 32,
  parameter int VL_W     = 6,
  parameter int OFFSET_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  compress_offset_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state_reg, state_next;
  logic [VL_W-1:0]     vl_reg;
  logic [VL_W-1:0]     src_idx_reg;
  logic [VL_W-1:0]     wcount_reg;
  logic [1:0]          wr_en_reg;
  logic [OFFSET_W-1:0] wr_idx0_reg;
  logic [OFFSET_W-1:0] wr_idx1_reg;
  logic                err_reg;

  logic                cou_ena;
  logic                cou_done;
  logic                start_ok;
  logic                last_pair;
  logic                lane1_ok;
  logic                err_set;
  logic [VL_W-1:0]     vl_clamped;
  logic [VL_W-1:0]     wr_pop;

  // Request decode, pair-position compares (one bit wider so idx+2 never wraps)
  always_comb begin
    vl_clamped = (bus.vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : bus.vl;
    start_ok   = (state_reg == IDLE) && bus.start;
    last_pair  = ({1'b0, src_idx_reg} + (VL_W+1)'(2)) >= {1'b0, vl_reg};
    lane1_ok   = ({1'b0, src_idx_reg} + (VL_W+1)'(1)) <  {1'b0, vl_reg};
    wr_pop     = VL_W'(wr_en_reg[0]) + VL_W'(wr_en_reg[1]);
    // Only pair 0 may still be checking mask bits; the unit must stay busy while enabled
    err_set    = cou_ena &&
                 ((bus.cou_checking_mask0_1 && (src_idx_reg != '0)) || !bus.cou_busy);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and offset-unit handshake
  always_comb begin
    state_next = state_reg;
    cou_ena    = 1'b0;
    cou_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = (vl_clamped == '0) ? FIN : RUN;
      end
      RUN: begin
        cou_ena  = !bus.stall;
        cou_done = cou_ena && last_pair;
        if (cou_done) state_next = DRAIN;
      end
      DRAIN: begin
        if (!bus.cou_busy && !bus.stall) state_next = FIN;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // VRF write request registers: hold under stall, load on each enabled pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_reg   <= '0;
      wr_idx0_reg <= '0;
      wr_idx1_reg <= '0;
    end else if (!bus.stall) begin
      if (cou_ena) begin
        // lane 1 of the final pair of an odd request has no source element
        wr_en_reg   <= {bus.cou_wen[1] && lane1_ok, bus.cou_wen[0]};
        wr_idx0_reg <= bus.cou_woffset0;
        wr_idx1_reg <= bus.cou_woffset1;
      end else begin
        wr_en_reg   <= '0;
      end
    end
  end

  // Request bookkeeping: vl latch, pair index, accepted-element count, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vl_reg      <= '0;
      src_idx_reg <= '0;
      wcount_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (!bus.stall) begin
        wcount_reg <= wcount_reg + wr_pop;
        if (cou_ena) src_idx_reg <= src_idx_reg + VL_W'(2);
      end
      if (err_set) err_reg <= 1'b1;
      if (start_ok) begin
        vl_reg      <= vl_clamped;
        src_idx_reg <= '0;
        wcount_reg  <= '0;
        err_reg     <= 1'b0;
      end
    end
  end

  assign bus.ready    = (state_reg == IDLE);
  assign bus.done     = (state_reg == FIN);
  assign bus.cou_ena  = cou_ena;
  assign bus.cou_done = cou_done;
  assign bus.src_idx  = src_idx_reg;
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_idx0  = wr_idx0_reg;
  assign bus.wr_idx1  = wr_idx1_reg;
  assign bus.wcount   = wcount_reg;
  assign bus.err      = err_reg;

endmodule
